alu_divider_seq: RTL and testbench

Iterative 16-bit restoring divider for the ALU. It executes divide and remainder operations using one shared 17-bit subtractor over 16 cycles. Operands and results use the same 16-bit two's-complement datapath and overflow/saturation conventions as the ALU adder, so the execute stage can mux its outputs next to the adder's. A start/done handshake stalls the pipeline while the divider is busy.

---
 rtl/alu_divider_seq_pkg.sv | 23 ++
 rtl/alu_divider_seq_div_step.sv | 32 +++
 rtl/alu_divider_seq.sv | 143 ++++++++++++++
 tb/tb_alu_divider_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_divider_seq_pkg.sv
// Shared ALU divider definitions: FSM encoding, iteration count and result constants.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package alu_divider_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } div_state_t;

    localparam int          DIV_ITER  = 16;
    localparam logic [15:0] SAT_POS   = 16'h7FFF;
    localparam logic [15:0] SAT_NEG   = 16'h8000;
    localparam logic [15:0] DIVZERO_Q = 16'hFFFF;

    // Two's-complement negate when neg is set; 0x8000 maps to itself, which the
    // divider then reads as the unsigned magnitude 0x8000.
    function automatic logic [15:0] neg_if(input logic [15:0] v, input logic neg);
        return neg ? (~v + 16'd1) : v;
    endfunction

endpackage

// File: rtl/alu_divider_seq_div_step.sv
// One restoring-division iteration: shift {rem,quot} left, trial-subtract divisor.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module div_step (
    input  logic [16:0] rem,
    input  logic [15:0] quot,
    input  logic [15:0] divisor,
    output logic [16:0] rem_nxt,
    output logic [15:0] quot_nxt
);

    logic [16:0] rem_sh;
    logic [17:0] trial;
    logic        borrow;

    // Shift, subtract, and keep the trial only when it did not go negative.
    // rem[16] set would mean the shifted value exceeds any 16-bit divisor, so it
    // suppresses the borrow (it never happens while rem < divisor holds).
    always_comb begin
        rem_sh = {rem[15:0], quot[15]};
        trial  = {1'b0, rem_sh} - {2'b00, divisor};
        borrow = trial[17] & ~rem[16];
        if (!borrow) begin
            rem_nxt  = trial[16:0];
            quot_nxt = {quot[14:0], 1'b1};
        end else begin
            rem_nxt  = rem_sh;
            quot_nxt = {quot[14:0], 1'b0};
        end
    end

endmodule

// File: rtl/alu_divider_seq.sv
// Iterative 16-bit signed/unsigned restoring divider with adder-style overflow/saturation.
// Latency: fixed 18 cycles from the accepted start edge to the one-cycle done pulse.
// Backpressure: start is honoured only when idle; busy stalls the pipeline, no queuing.
module alu_divider_seq
    import alu_divider_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             sat,
    input  logic [WIDTH-1:0] Div_In1,
    input  logic [WIDTH-1:0] Div_In2,
    output logic [WIDTH-1:0] Quot_Out,
    output logic [WIDTH-1:0] Rem_Out,
    output logic             Ovfl,
    output logic             DivZero,
    output logic             busy,
    output logic             done
);

    div_state_t       state_q, state_nxt;
    logic [3:0]       cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] in1_q;
    logic             q_neg_q, r_neg_q, dz_q, ov_q, sat_q;

    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quot_step;
    logic [WIDTH-1:0] quot_fix, rem_fix;
    logic             accept;
    logic             sgn1, sgn2;

    // A start coinciding with the done pulse is dropped, so the next accepted
    // start is strictly after done.
    assign accept = (state_q == ST_IDLE) && start && !done;
    assign sgn1   = signed_op & Div_In1[WIDTH-1];
    assign sgn2   = signed_op & Div_In2[WIDTH-1];

    div_step u_step (
        .rem      (rem_q),
        .quot     (quot_q),
        .divisor  (dvs_q),
        .rem_nxt  (rem_step),
        .quot_nxt (quot_step)
    );

    // Next-state logic: idle until accepted, 16 iterations, one fix-up cycle.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_nxt = ST_BUSY;
            ST_BUSY: if (cnt_q == 4'(DIV_ITER - 1)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nxt;
    end

    // Iteration counter: cleared on accept, advances once per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst)                     cnt_q <= '0;
        else if (accept)             cnt_q <= '0;
        else if (state_q == ST_BUSY) cnt_q <= cnt_q + 4'd1;
    end

    // Operand capture (magnitudes and sign/special-case flags) and the shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q   <= '0;
            quot_q  <= '0;
            dvs_q   <= '0;
            in1_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            sat_q   <= 1'b0;
        end else if (accept) begin
            rem_q   <= '0;
            quot_q  <= neg_if(Div_In1, sgn1);
            dvs_q   <= neg_if(Div_In2, sgn2);
            in1_q   <= Div_In1;
            q_neg_q <= sgn1 ^ sgn2;
            r_neg_q <= sgn1;
            dz_q    <= (Div_In2 == '0);
            ov_q    <= signed_op && (Div_In1 == SAT_NEG) && (Div_In2 == DIVZERO_Q);
            sat_q   <= sat;
        end else if (state_q == ST_BUSY) begin
            rem_q   <= rem_step;
            quot_q  <= quot_step;
        end
    end

    // Result fix-up: divide-by-zero and overflow override the iterated result,
    // otherwise restore the signs stripped at capture.
    always_comb begin
        quot_fix = quot_q;
        rem_fix  = rem_q[WIDTH-1:0];
        if (dz_q) begin
            quot_fix = DIVZERO_Q;
            rem_fix  = in1_q;
        end else if (ov_q) begin
            quot_fix = sat_q ? SAT_POS : SAT_NEG;
            rem_fix  = '0;
        end else begin
            quot_fix = neg_if(quot_q, q_neg_q);
            rem_fix  = neg_if(rem_q[WIDTH-1:0], r_neg_q);
        end
    end

    // Registered outputs: busy follows the upcoming state, done trails DONE by one
    // edge, and results load only when leaving DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            Quot_Out <= '0;
            Rem_Out  <= '0;
            Ovfl     <= 1'b0;
            DivZero  <= 1'b0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
            done <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                Quot_Out <= quot_fix;
                Rem_Out  <= rem_fix;
                Ovfl     <= ov_q;
                DivZero  <= dz_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_divider_seq.sv
module tb_alu_divider_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic        sat;
    logic [15:0] Div_In1;
    logic [15:0] Div_In2;
    logic [15:0] Quot_Out;
    logic [15:0] Rem_Out;
    logic        Ovfl;
    logic        DivZero;
    logic        busy;
    logic        done;

    alu_divider_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .sat       (sat),
        .Div_In1   (Div_In1),
        .Div_In2   (Div_In2),
        .Quot_Out  (Quot_Out),
        .Rem_Out   (Rem_Out),
        .Ovfl      (Ovfl),
        .DivZero   (DivZero),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sg;
        logic [15:0] q;
        logic [15:0] r;
        logic        ov;
        logic        dz;
        int          scyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: integer division of the spec's values, with the special cases by rule.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic sg, input logic st);
        exp_t e;
        int   x, y;
        e.a = a; e.b = b; e.sg = sg; e.ov = 1'b0; e.dz = 1'b0; e.scyc = 0;
        x = sg ? int'($signed(a)) : int'(a);
        y = sg ? int'($signed(b)) : int'(b);
        if (y == 0) begin
            e.q = 16'hFFFF; e.r = a; e.dz = 1'b1;
        end else if (x == -32768 && y == -1) begin
            e.ov = 1'b1; e.r = 16'h0000; e.q = st ? 16'h7FFF : 16'h8000;
        end else begin
            e.q = 16'(x / y);
            e.r = 16'(x % y);
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [15:0] a, input logic [15:0] b, input logic sg,
                                input logic [15:0] q, input logic [15:0] r,
                                input logic ov, input logic dz);
        exp_t e;
        e.a = a; e.b = b; e.sg = sg; e.q = q; e.r = r; e.ov = ov; e.dz = dz; e.scyc = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        int   qi, ri, ai, bi;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: done seen with no request outstanding (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("quot", Quot_Out, e.q);
                check("rem", Rem_Out, e.r);
                check("ovfl", Ovfl, e.ov);
                check("divzero", DivZero, e.dz);
                check("latency", cyc - e.scyc, 18);
                if (!e.dz && !e.ov) begin
                    qi = e.sg ? int'($signed(Quot_Out)) : int'(Quot_Out);
                    ri = e.sg ? int'($signed(Rem_Out))  : int'(Rem_Out);
                    ai = e.sg ? int'($signed(e.a))      : int'(e.a);
                    bi = e.sg ? int'($signed(e.b))      : int'(e.b);
                    check("identity", qi * bi + ri, ai);
                    check("rem_bound", ((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi)) ? 1 : 0, 1);
                end
            end
        end
    end

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic sg, input logic st);
        start = 1'b1; Div_In1 = a; Div_In2 = b; signed_op = sg; sat = st;
    endtask

    // Issue one operation, then wait (bounded) for done while counting busy cycles.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sg,
                          input logic st, input exp_t e);
        int n, bcnt;
        @(negedge clk);
        drive(a, b, sg, st);
        e.scyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        n = 1; bcnt = 0;
        while (!done && n < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1'b1);
        check("busy_cycles", bcnt, 17);
        check("busy_at_done", busy, 1'b0);
    endtask

    function automatic logic [15:0] rnd_val();
        case ($urandom_range(0, 9))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'($urandom_range(1, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, b;
        logic        st;
        int          s, n;
        rst = 1'b1; start = 1'b0; signed_op = 1'b0; sat = 1'b0;
        Div_In1 = '0; Div_In2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_quot", Quot_Out, 16'h0000);
        check("rst_rem", Rem_Out, 16'h0000);
        check("rst_flags", {Ovfl, DivZero}, 2'b00);

        // Directed cases with hand-computed results.
        run_op(16'd100, 16'd7, 1'b0, 1'b0, mk(16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 1'b0));
        run_op(16'hFF9C, 16'd7, 1'b1, 1'b0, mk(16'hFF9C, 16'd7, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0));
        run_op(16'd100, 16'hFFF9, 1'b1, 1'b0, mk(16'd100, 16'hFFF9, 1'b1, 16'hFFF2, 16'd2, 1'b0, 1'b0));
        run_op(16'h8000, 16'hFFFF, 1'b1, 1'b1, mk(16'h8000, 16'hFFFF, 1'b1, 16'h7FFF, 16'h0000, 1'b1, 1'b0));
        run_op(16'h8000, 16'hFFFF, 1'b1, 1'b0, mk(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b1, 1'b0));
        run_op(16'h1234, 16'h0000, 1'b1, 1'b0, mk(16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b0, 1'b1));
        run_op(16'h1234, 16'h0000, 1'b0, 1'b1, mk(16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b0, 1'b1));
        run_op(16'h8000, 16'hFFFF, 1'b0, 1'b1, mk(16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0));
        run_op(16'd5000, 16'd77, 1'b0, 1'b0, model(16'd5000, 16'd77, 1'b0, 1'b0));

        // Reset in the middle of BUSY: no done may follow (the monitor flags any).
        @(negedge clk);
        drive(16'h4321, 16'd5, 1'b0, 1'b0);
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc - s < 9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_quot", Quot_Out, 16'h0000);
        check("midrst_rem", Rem_Out, 16'h0000);
        check("midrst_flags", {Ovfl, DivZero}, 2'b00);
        repeat (25) @(negedge clk);

        // Starts during BUSY and on the done cycle are ignored: exactly one done.
        @(negedge clk);
        drive(16'd1000, 16'd3, 1'b0, 1'b0);
        s = cyc;
        sb.push_back(mk(16'd1000, 16'd3, 1'b0, 16'd333, 16'd1, 1'b0, 1'b0));
        sb[sb.size() - 1].scyc = s;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            if (cyc - s == 5) drive(16'd9, 16'd2, 1'b0, 1'b0);
            else              start = 1'b0;
            @(negedge clk);
            n++;
        end
        check("ign_done_seen", done, 1'b1);
        drive(16'd77, 16'd7, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("ign_busy_after_done", busy, 1'b0);
        repeat (25) @(negedge clk);
        check("ign_hold_quot", Quot_Out, 16'd333);

        // Randomized sweep against the reference model, both signedness modes.
        for (int sg = 0; sg < 2; sg++) begin
            for (int i = 0; i < 1200; i++) begin
                a  = rnd_val();
                b  = rnd_val();
                st = 1'($urandom_range(0, 1));
                run_op(a, b, 1'(sg), st, model(a, b, 1'(sg), st));
            end
        end

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
